// File: rtl/fpu_seq_pkg.sv
// Shared types and helpers for the FPU operand/result sequencer.
//   seq_state_t  : sequencer FSM states
//   fpu_result_t : one captured FPU result (data, status, flags), 37 bits packed
//   idx_width()  : index width for an N-entry memory, never less than 1 bit
package fpu_seq_pkg;

    localparam int RES_W = 37;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT,
        CAPTURE,
        DONE
    } seq_state_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  status;
        logic        flags;
    } fpu_result_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fpu_result_buf.sv
// Result storage for the sequencer: DEPTH entries of one packed fpu_result_t.
// One write port and one registered read port (1-cycle latency).
//   clk_i    : clock, rising edge
//   rst_i    : synchronous active-high reset, clears the read register only
//   we_i     : write enable
//   waddr_i  : write index; out-of-range writes are dropped
//   wdata_i  : packed result to store
//   raddr_i  : read index; out-of-range reads return 0
//   rdata_o  : registered read data
// A read and a write to the same entry in one cycle returns the old contents.
module fpu_result_buf
    import fpu_seq_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = idx_width(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [RES_W-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [RES_W-1:0] rdata_o
);

    logic [RES_W-1:0] mem_q [DEPTH];
    logic [RES_W-1:0] rdata_q;

    // Storage is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (we_i && (int'(waddr_i) < DEPTH)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (int'(raddr_i) < DEPTH) begin
            rdata_q <= mem_q[raddr_i];
        end else begin
            rdata_q <= '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fpu_op_sequencer.sv
// Initiator side of the FPU operand/result interface. The host loads operand
// pairs, pulses start, and the sequencer feeds each pair to the FPU, restarts
// it, waits its compute latency and captures the result into a buffer that
// the host reads back.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; operand memory writable
// LOAD    | register operands of pair idx, pulse fpu_rst_out
// WAIT    | FPU computing; wait_q runs 0..FPU_LATENCY-1
// CAPTURE | store FPU result for pair idx, advance or finish
// DONE    | one-cycle done pulse, then back to IDLE
//
// Ports:
//   clock100KHz, reset     : clock (rising edge), synchronous active-high reset
//   start, busy, done      : run request, run-in-progress, completion pulse
//   cfg_we/addr/a/b        : operand pair write (IDLE only)
//   op_A_out, op_B_out     : operands to the FPU
//   fpu_rst_out            : one-cycle FPU restart per pair
//   fpu_data/status/flags_in : FPU result inputs
//   rd_addr, rd_data/status/flags : registered result read-back
//   count_out              : results captured in the current/last run
module fpu_op_sequencer
    import fpu_seq_pkg::*;
#(
    parameter int N_PAIRS     = 8,
    parameter int FPU_LATENCY = 4,
    localparam int IW = idx_width(N_PAIRS),
    localparam int CW = $clog2(N_PAIRS + 1),
    localparam int WW = idx_width(FPU_LATENCY)
) (
    input  logic          clock100KHz,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    input  logic          cfg_we,
    input  logic [IW-1:0] cfg_addr,
    input  logic [31:0]   cfg_a,
    input  logic [31:0]   cfg_b,
    output logic [31:0]   op_A_out,
    output logic [31:0]   op_B_out,
    output logic          fpu_rst_out,
    input  logic [31:0]   fpu_data_in,
    input  logic [3:0]    fpu_status_in,
    input  logic          fpu_flags_in,
    input  logic [IW-1:0] rd_addr,
    output logic [31:0]   rd_data,
    output logic [3:0]    rd_status,
    output logic          rd_flags,
    output logic [CW-1:0] count_out
);

    localparam logic [IW-1:0] LAST_IDX  = IW'(N_PAIRS - 1);
    localparam logic [WW-1:0] LAST_WAIT = WW'(FPU_LATENCY - 1);

    seq_state_t    state_q, state_d;
    logic [IW-1:0] idx_q;
    logic [WW-1:0] wait_q;
    logic [CW-1:0] count_q;
    logic [31:0]   op_a_q, op_b_q;

    logic [31:0]   op_a_mem [N_PAIRS];
    logic [31:0]   op_b_mem [N_PAIRS];

    fpu_result_t   wr_res;
    fpu_result_t   rd_res;
    logic [RES_W-1:0] rd_vec;

    // Operand memory is frozen outside IDLE, so a run always sees the pairs
    // that were present when it started.
    always_ff @(posedge clock100KHz) begin
        if (cfg_we && (state_q == IDLE) && (int'(cfg_addr) < N_PAIRS)) begin
            op_a_mem[cfg_addr] <= cfg_a;
            op_b_mem[cfg_addr] <= cfg_b;
        end
    end

    always_ff @(posedge clock100KHz) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            wait_q  <= '0;
            count_q <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        idx_q   <= '0;
                        count_q <= '0;
                    end
                end
                LOAD: begin
                    op_a_q <= op_a_mem[idx_q];
                    op_b_q <= op_b_mem[idx_q];
                    wait_q <= '0;
                end
                WAIT: begin
                    wait_q <= wait_q + 1'b1;
                end
                CAPTURE: begin
                    count_q <= count_q + 1'b1;
                    // idx stops at the last pair rather than wrapping.
                    if (idx_q != LAST_IDX) begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        busy        = 1'b0;
        done        = 1'b0;
        fpu_rst_out = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = LOAD;
            end
            LOAD: begin
                busy        = 1'b1;
                fpu_rst_out = 1'b1;
                state_d     = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (wait_q == LAST_WAIT) state_d = CAPTURE;
            end
            CAPTURE: begin
                busy    = 1'b1;
                state_d = (idx_q == LAST_IDX) ? DONE : LOAD;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FPU inputs are sampled only while in CAPTURE; anything the FPU drives
    // during its latency window never reaches the buffer.
    assign wr_res = '{data: fpu_data_in, status: fpu_status_in, flags: fpu_flags_in};

    fpu_result_buf #(
        .DEPTH (N_PAIRS)
    ) u_result_buf (
        .clk_i   (clock100KHz),
        .rst_i   (reset),
        .we_i    (state_q == CAPTURE),
        .waddr_i (idx_q),
        .wdata_i (wr_res),
        .raddr_i (rd_addr),
        .rdata_o (rd_vec)
    );

    assign rd_res    = rd_vec;
    assign rd_data   = rd_res.data;
    assign rd_status = rd_res.status;
    assign rd_flags  = rd_res.flags;

    assign op_A_out  = op_a_q;
    assign op_B_out  = op_b_q;
    assign count_out = count_q;

endmodule

// File: tb/tb_fpu_op_sequencer.sv
module tb_fpu_op_sequencer;

    localparam int N8 = 8;
    localparam int L8 = 4;
    localparam int N1 = 1;
    localparam int L1 = 1;
    localparam int RUN8 = N8 * (L8 + 2) + 1;
    localparam int RUN1 = N1 * (L1 + 2) + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic reset;

    // Main instance: 8 pairs, latency 4
    logic        a_start, a_busy, a_done, a_cfg_we, a_frst;
    logic [2:0]  a_cfg_addr, a_rd_addr;
    logic [31:0] a_cfg_a, a_cfg_b, a_opA, a_opB, a_fdata, a_rd_data;
    logic [3:0]  a_fstat, a_rd_status, a_count;
    logic        a_fflag, a_rd_flags;

    // Small instance: 1 pair, latency 1
    logic        b_start, b_busy, b_done, b_cfg_we, b_frst;
    logic [0:0]  b_cfg_addr, b_rd_addr;
    logic [31:0] b_cfg_a, b_cfg_b, b_opA, b_opB, b_fdata, b_rd_data;
    logic [3:0]  b_fstat, b_rd_status;
    logic [0:0]  b_count;
    logic        b_fflag, b_rd_flags;

    fpu_op_sequencer #(.N_PAIRS(N8), .FPU_LATENCY(L8)) dut (
        .clock100KHz(clk), .reset(reset), .start(a_start), .busy(a_busy), .done(a_done),
        .cfg_we(a_cfg_we), .cfg_addr(a_cfg_addr), .cfg_a(a_cfg_a), .cfg_b(a_cfg_b),
        .op_A_out(a_opA), .op_B_out(a_opB), .fpu_rst_out(a_frst),
        .fpu_data_in(a_fdata), .fpu_status_in(a_fstat), .fpu_flags_in(a_fflag),
        .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_status(a_rd_status),
        .rd_flags(a_rd_flags), .count_out(a_count)
    );

    fpu_op_sequencer #(.N_PAIRS(N1), .FPU_LATENCY(L1)) dut1 (
        .clock100KHz(clk), .reset(reset), .start(b_start), .busy(b_busy), .done(b_done),
        .cfg_we(b_cfg_we), .cfg_addr(b_cfg_addr), .cfg_a(b_cfg_a), .cfg_b(b_cfg_b),
        .op_A_out(b_opA), .op_B_out(b_opB), .fpu_rst_out(b_frst),
        .fpu_data_in(b_fdata), .fpu_status_in(b_fstat), .fpu_flags_in(b_fflag),
        .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_status(b_rd_status),
        .rd_flags(b_rd_flags), .count_out(b_count)
    );

    // Stub FPUs: result valid only on the cycle when LATENCY whole cycles have
    // elapsed since release from reset; random garbage on every other cycle.
    int a_low = 1000;
    int b_low = 1000;
    always @(negedge clk) begin
        if (a_frst) a_low = 0; else if (a_low < 1000) a_low++;
        if (a_low == L8 + 1) begin
            a_fdata = a_opA ^ a_opB; a_fstat = a_opA[3:0]; a_fflag = a_opB[0];
        end else begin
            a_fdata = $urandom; a_fstat = 4'($urandom); a_fflag = 1'($urandom);
        end
        if (b_frst) b_low = 0; else if (b_low < 1000) b_low++;
        if (b_low == L1 + 1) begin
            b_fdata = b_opA ^ b_opB; b_fstat = b_opA[3:0]; b_fflag = b_opB[0];
        end else begin
            b_fdata = $urandom; b_fstat = 4'($urandom); b_fflag = 1'($urandom);
        end
    end

    // Reference model: operand pairs as the host believes they are stored.
    logic [31:0] ref_a [N8];
    logic [31:0] ref_b [N8];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_ref;
        for (int i = 0; i < N8; i++) begin
            ref_a[i] = $urandom;
            ref_b[i] = $urandom;
        end
    endtask

    task automatic load8;
        for (int i = 0; i < N8; i++) begin
            a_cfg_we = 1'b1; a_cfg_addr = 3'(i); a_cfg_a = ref_a[i]; a_cfg_b = ref_b[i];
            tick;
        end
        a_cfg_we = 1'b0;
    endtask

    // Drives one run on the main instance and reports what it observed.
    task automatic run8(input bit poke, output int cyc, output int rst_cycles,
                        output int busy_bad, output int cnt_at_done);
        cyc = 0; rst_cycles = 0; busy_bad = 0; cnt_at_done = -1;
        a_start = 1'b1;
        while (cyc < 200) begin
            tick;
            cyc++;
            a_start = 1'b0;
            a_cfg_we = 1'b0;
            if (poke && cyc == 10) begin
                a_start = 1'b1; a_cfg_we = 1'b1; a_cfg_addr = 3'd2;
                a_cfg_a = ~ref_a[2]; a_cfg_b = ~ref_b[2];
            end
            if (a_frst) rst_cycles++;
            if (a_done) begin
                cnt_at_done = int'(a_count);
                if (a_busy) busy_bad++;
                break;
            end
            if (!a_busy) busy_bad++;
        end
        a_start = 1'b0;
        a_cfg_we = 1'b0;
    endtask

    task automatic read8(input int idx, output logic [31:0] d, output logic [3:0] s,
                         output logic f);
        a_rd_addr = 3'(idx);
        tick;
        d = a_rd_data; s = a_rd_status; f = a_rd_flags;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick; tick;
        total++;
        if ({a_busy, a_done, a_frst, a_count} !== 7'd0) begin
            bad++; $display("FAIL reset_ctrl: busy=%b done=%b frst=%b count=%0d want all 0",
                            a_busy, a_done, a_frst, a_count);
        end
        total++;
        if ({a_opA, a_opB} !== 64'd0) begin
            bad++; $display("FAIL reset_ops: opA=%h opB=%h want 0", a_opA, a_opB);
        end
        total++;
        if ({a_rd_data, a_rd_status, a_rd_flags} !== 37'd0) begin
            bad++; $display("FAIL reset_rd: data=%h status=%h flags=%b want 0",
                            a_rd_data, a_rd_status, a_rd_flags);
        end
        total++;
        if ({b_busy, b_done, b_frst, b_count} !== 4'd0) begin
            bad++; $display("FAIL reset_small: busy=%b done=%b frst=%b count=%0d want 0",
                            b_busy, b_done, b_frst, b_count);
        end
        reset = 1'b0;
        tick;
    endtask

    task automatic check_results(input string tag);
        logic [31:0] d; logic [3:0] s; logic f;
        for (int i = 0; i < N8; i++) begin
            read8(i, d, s, f);
            total++;
            if ({d, s, f} !== {ref_a[i] ^ ref_b[i], ref_a[i][3:0], ref_b[i][0]}) begin
                bad++;
                $display("FAIL %s_result[%0d]: got %h/%h/%b want %h/%h/%b", tag, i, d, s, f,
                         ref_a[i] ^ ref_b[i], ref_a[i][3:0], ref_b[i][0]);
            end
        end
    endtask

    task automatic test_basic_run;
        int cyc, rc, bb, cnt;
        logic [31:0] d; logic [3:0] s; logic f;
        randomize_ref;
        ref_a[0] = 32'h3F80_0000;
        ref_b[0] = 32'h4000_0000;
        load8;
        run8(1'b0, cyc, rc, bb, cnt);
        total++;
        if (cyc !== RUN8) begin bad++; $display("FAIL basic_len: got %0d want %0d", cyc, RUN8); end
        total++;
        if (rc !== N8) begin bad++; $display("FAIL basic_fpu_rst: got %0d want %0d", rc, N8); end
        total++;
        if (bb !== 0) begin bad++; $display("FAIL basic_busy: %0d bad cycles want 0", bb); end
        total++;
        if (cnt !== N8) begin bad++; $display("FAIL basic_count: got %0d want %0d", cnt, N8); end
        tick;
        total++;
        if ({a_busy, a_done} !== 2'b00) begin
            bad++; $display("FAIL basic_idle: busy=%b done=%b want 0 0", a_busy, a_done);
        end
        read8(0, d, s, f);
        total++;
        if ({d, s, f} !== {32'h7F80_0000, 4'h0, 1'b0}) begin
            bad++; $display("FAIL basic_pair0: got %h/%h/%b want 7f800000/0/0", d, s, f);
        end
        check_results("basic");
    endtask

    task automatic test_capture_timing;
        int cyc, rc, bb, cnt;
        randomize_ref;
        load8;
        run8(1'b0, cyc, rc, bb, cnt);
        total++;
        if (cyc !== RUN8) begin bad++; $display("FAIL timing_len: got %0d want %0d", cyc, RUN8); end
        tick;
        check_results("timing");
    endtask

    task automatic test_mid_run_pokes;
        int cyc, rc, bb, cnt;
        randomize_ref;
        load8;
        run8(1'b1, cyc, rc, bb, cnt);
        total++;
        if (cyc !== RUN8) begin bad++; $display("FAIL poke_len: got %0d want %0d", cyc, RUN8); end
        total++;
        if (cnt !== N8) begin bad++; $display("FAIL poke_count: got %0d want %0d", cnt, N8); end
        // Now in DONE: start and cfg_we here must both be ignored.
        a_start = 1'b1; a_cfg_we = 1'b1; a_cfg_addr = 3'd0;
        a_cfg_a = ~ref_a[0]; a_cfg_b = ~ref_b[0];
        tick;
        a_start = 1'b0; a_cfg_we = 1'b0;
        total++;
        if ({a_busy, a_done} !== 2'b00) begin
            bad++; $display("FAIL done_start: busy=%b done=%b want 0 0", a_busy, a_done);
        end
        tick;
        total++;
        if (a_busy !== 1'b0) begin bad++; $display("FAIL done_start2: busy=%b want 0", a_busy); end
        check_results("poke");
        // Rerun without reloading: operand memory must be unmodified.
        run8(1'b0, cyc, rc, bb, cnt);
        total++;
        if (cyc !== RUN8) begin bad++; $display("FAIL rerun_len: got %0d want %0d", cyc, RUN8); end
        tick;
        check_results("rerun");
    endtask

    task automatic test_reset_mid_run;
        int cyc, rc, bb, cnt, dones;
        a_start = 1'b1;
        // Pair 3 LOAD is cycle 19 after start, WAIT 20..23.
        for (int k = 1; k <= 21; k++) begin
            tick;
            a_start = 1'b0;
        end
        total++;
        if ({a_busy, a_count} !== {1'b1, 4'd3}) begin
            bad++; $display("FAIL midrun_state: busy=%b count=%0d want 1 3", a_busy, a_count);
        end
        reset = 1'b1;
        tick;
        reset = 1'b0;
        total++;
        if ({a_busy, a_done, a_frst, a_count, a_opA} !== 39'd0) begin
            bad++; $display("FAIL abort_state: busy=%b done=%b frst=%b count=%0d opA=%h want 0",
                            a_busy, a_done, a_frst, a_count, a_opA);
        end
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            tick;
            if (a_done || a_busy) dones++;
        end
        total++;
        if (dones !== 0) begin bad++; $display("FAIL abort_quiet: %0d active cycles want 0", dones); end
        randomize_ref;
        load8;
        run8(1'b0, cyc, rc, bb, cnt);
        total++;
        if ({cyc, cnt} !== {RUN8, N8}) begin
            bad++; $display("FAIL post_abort: len=%0d count=%0d want %0d %0d", cyc, cnt, RUN8, N8);
        end
        tick;
        check_results("post_abort");
    endtask

    task automatic test_small;
        logic [31:0] sa, sb;
        int cyc;
        sa = $urandom; sb = $urandom;
        b_cfg_we = 1'b1; b_cfg_addr = 1'b0; b_cfg_a = sa; b_cfg_b = sb;
        tick;
        b_cfg_addr = 1'b1; b_cfg_a = ~sa; b_cfg_b = ~sb;
        tick;
        b_cfg_we = 1'b0;
        b_start = 1'b1;
        cyc = 0;
        while (cyc < 50) begin
            tick;
            cyc++;
            b_start = 1'b0;
            if (b_done) break;
        end
        total++;
        if (cyc !== RUN1) begin bad++; $display("FAIL small_len: got %0d want %0d", cyc, RUN1); end
        total++;
        if (b_count !== 1'b1) begin bad++; $display("FAIL small_count: got %0d want 1", b_count); end
        b_rd_addr = 1'b0;
        tick;
        total++;
        if ({b_rd_data, b_rd_status, b_rd_flags} !== {sa ^ sb, sa[3:0], sb[0]}) begin
            bad++; $display("FAIL small_result: got %h/%h/%b want %h/%h/%b", b_rd_data,
                            b_rd_status, b_rd_flags, sa ^ sb, sa[3:0], sb[0]);
        end
        b_rd_addr = 1'b1;
        tick;
        total++;
        if ({b_rd_data, b_rd_status, b_rd_flags} !== 37'd0) begin
            bad++; $display("FAIL small_oob_read: got %h/%h/%b want 0", b_rd_data, b_rd_status,
                            b_rd_flags);
        end
    endtask

    initial begin
        reset = 1'b1;
        a_start = 1'b0; a_cfg_we = 1'b0; a_cfg_addr = '0; a_cfg_a = '0; a_cfg_b = '0;
        a_rd_addr = '0;
        b_start = 1'b0; b_cfg_we = 1'b0; b_cfg_addr = '0; b_cfg_a = '0; b_cfg_b = '0;
        b_rd_addr = '0;
        a_fdata = '0; a_fstat = '0; a_fflag = 1'b0;
        b_fdata = '0; b_fstat = '0; b_fflag = 1'b0;
        test_reset;
        test_basic_run;
        test_capture_timing;
        test_mid_run_pokes;
        test_reset_mid_run;
        test_small;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
